reg_file_bypass: RTL and testbench
==================================

Name: reg_file_bypass

Overview:
Parametrised next-generation register file for the five-stage pipeline. It holds N_GPR general registers of DATA_W bits, a 2*DATA_W-bit PC and SP accessed in half-words, and a FLAG_W-bit flag register. All accesses use a single rising clock edge. Reads are registered with write-to-read bypass, replacing split-edge timing. SP supports dedicated push/pop adjust and flags support a dedicated ALU update port, so decode, execute and memory stages share the block without extra write-port pressure.

Parameters:
DATA_W, 16, general register / port width
N_GPR, 8, number of general registers (2..13)
ADDR_W, 4, register address width
FLAG_W, 4, flag register width (<= DATA_W)
PC_RST, 0, PC reset value (2*DATA_W bits)
SP_RST, 4095, SP reset value (2*DATA_W bits)
SP_STEP, 1, SP push/pop step

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous reset, active-low
rd_en  in  1  capture read ports this cycle (active high)
rd_addr1, rd_addr2  in  ADDR_W  read addresses
rd_hi1, rd_hi2  in  1  half select for PC/SP reads: 0 = [DATA_W-1:0], 1 = upper half
rd_data1, rd_data2  out  DATA_W  registered read data
wr_en  in  1  write enable (active high)
wr_addr  in  ADDR_W  write address
wr_hi  in  1  half select for PC/SP writes
wr_data  in  DATA_W  write data
sp_op  in  2  00 none, 01 push (SP -= SP_STEP), 10 pop (SP += SP_STEP), 11 none
flag_we  in  1  ALU flag update
flag_in  in  FLAG_W  new flags
sp_out  out  2*DATA_W  current SP (registered state)
flags_out  out  FLAG_W  current flags (registered state)

Behaviour:
- Address map: 0..N_GPR-1 = GPR. N_GPR = PC. N_GPR+1 = SP. N_GPR+2 = FLAGS. Higher addresses are unmapped.
- Reset (rst=0 at rising edge) overrides all other inputs:
  - GPRs = 0, PC = PC_RST, SP = SP_RST, flags = 0.
  - rd_data1/2 = 0; sp_out = SP_RST; flags_out = 0.
- Write (wr_en=1):
  - GPR: full-word write.
  - PC/SP: only the half selected by wr_hi is written; the other half is kept.
  - FLAGS: takes wr_data[FLAG_W-1:0].
  - Unmapped address: write is ignored.
- SP adjust:
  - Modulo 2^(2*DATA_W) on the full 32-bit value; wraps 0 -> all-ones on push and all-ones -> 0 on pop.
  - If wr_en targets SP in the same cycle, the write port wins and sp_op is ignored.
- Flags: if wr_en targets FLAGS and flag_we=1 in the same cycle, the write port wins.
- Read:
  - rd_en=1: rd_dataN captures at the rising edge, one-cycle latency.
  - rd_en=0: rd_dataN holds its previous value.
  - FLAGS reads zero-extended; unmapped addresses read 0.
- Bypass: the captured value is the post-edge register value, including all of that cycle's updates (write, sp_op, flag_we), resolved per the priorities above. A read and write to the same address in one cycle returns the new data. For a half-word SP/PC read this applies only when the selected half is the one written. Both read ports bypass independently.
- sp_out and flags_out are the register contents (no bypass) and update the cycle after a change.

Test Plan:
- Reset then rd_en=1, rd_addr1=N_GPR+1, rd_hi1=0, rd_addr2=N_GPR+1, rd_hi2=1 -> next cycle rd_data1=0x0FFF, rd_data2=0x0000; sp_out=0x00000FFF.
- Write R3=0xBEEF with rd_addr1=3 in the same cycle -> rd_data1=0xBEEF next cycle (bypass). Then rd_en=0 with a different address -> rd_data1 holds 0xBEEF.
- Write SP high half 0x1234, then low half 0x0000; push once -> sp_out=0x1233FFFF. Pop twice -> 0x12340001. Set SP=0, push -> 0xFFFFFFFF.
- wr_en to SP (low half 0x00AA) with sp_op=01 in the same cycle -> SP low = 0x00AA, no decrement. wr_en to FLAGS 0x5 with flag_we=1, flag_in=0xA -> flags_out=0x5.
- Write to address 14 with 0xFFFF -> no register changes; rd_addr1=14 -> rd_data1=0.
- Assert rst=0 during a write to R1 and a push -> R1=0, SP=0x00000FFF, rd_data1/2=0.

Source files
------------

// File: rtl/reg_file_bypass.sv
// Register file for the five-stage pipeline: GPRs, half-word PC/SP, flags.
// Single-edge registered reads that see the same cycle's updates (write-to-read bypass).
module reg_file_bypass #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_GPR  = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned FLAG_W = 4,
    parameter logic [2*DATA_W-1:0] PC_RST = '0,
    parameter logic [2*DATA_W-1:0] SP_RST = (2*DATA_W)'(4095),
    parameter int unsigned SP_STEP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr1,
    input  logic [ADDR_W-1:0]     rd_addr2,
    input  logic                  rd_hi1,
    input  logic                  rd_hi2,
    output logic [DATA_W-1:0]     rd_data1,
    output logic [DATA_W-1:0]     rd_data2,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic                  wr_hi,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [1:0]            sp_op,
    input  logic                  flag_we,
    input  logic [FLAG_W-1:0]     flag_in,
    output logic [2*DATA_W-1:0]   sp_out,
    output logic [FLAG_W-1:0]     flags_out
);

    localparam int unsigned REG_W = 2 * DATA_W;
    localparam logic [ADDR_W-1:0] PC_ADDR    = ADDR_W'(N_GPR);
    localparam logic [ADDR_W-1:0] SP_ADDR    = ADDR_W'(N_GPR + 1);
    localparam logic [ADDR_W-1:0] FLAGS_ADDR = ADDR_W'(N_GPR + 2);

    logic [DATA_W-1:0] gpr_q   [N_GPR];
    logic [DATA_W-1:0] gpr_nxt [N_GPR];
    logic [REG_W-1:0]  pc_q, pc_nxt;
    logic [REG_W-1:0]  sp_q, sp_nxt;
    logic [FLAG_W-1:0] flags_q, flags_nxt;

    logic              wr_sp, wr_flags;
    logic [ADDR_W-1:0] rd_addr [2];
    logic              rd_hi   [2];
    logic [DATA_W-1:0] rd_nxt  [2];

    assign wr_sp    = wr_en && (wr_addr == SP_ADDR);
    assign wr_flags = wr_en && (wr_addr == FLAGS_ADDR);

    assign rd_addr[0] = rd_addr1;
    assign rd_addr[1] = rd_addr2;
    assign rd_hi[0]   = rd_hi1;
    assign rd_hi[1]   = rd_hi2;

    // Next register state; the write port has priority over sp_op and flag_we
    always_comb begin
        gpr_nxt   = gpr_q;
        pc_nxt    = pc_q;
        sp_nxt    = sp_q;
        flags_nxt = flags_q;

        if (!wr_sp) begin
            case (sp_op)
                2'b01:   sp_nxt = sp_q - REG_W'(SP_STEP);
                2'b10:   sp_nxt = sp_q + REG_W'(SP_STEP);
                default: sp_nxt = sp_q;
            endcase
        end

        if (flag_we && !wr_flags) begin
            flags_nxt = flag_in;
        end

        if (wr_en) begin
            for (int i = 0; i < int'(N_GPR); i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    gpr_nxt[i] = wr_data;
                end
            end
            if (wr_addr == PC_ADDR) begin
                if (wr_hi) pc_nxt[REG_W-1:DATA_W] = wr_data;
                else       pc_nxt[DATA_W-1:0]     = wr_data;
            end
            if (wr_sp) begin
                if (wr_hi) sp_nxt[REG_W-1:DATA_W] = wr_data;
                else       sp_nxt[DATA_W-1:0]     = wr_data;
            end
            if (wr_flags) begin
                flags_nxt = wr_data[FLAG_W-1:0];
            end
        end
    end

    // Read muxes select from post-update state so captures include this cycle's changes
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_nxt[p] = '0;
            for (int i = 0; i < int'(N_GPR); i++) begin
                if (rd_addr[p] == ADDR_W'(i)) begin
                    rd_nxt[p] = gpr_nxt[i];
                end
            end
            if (rd_addr[p] == PC_ADDR) begin
                rd_nxt[p] = rd_hi[p] ? pc_nxt[REG_W-1:DATA_W] : pc_nxt[DATA_W-1:0];
            end
            if (rd_addr[p] == SP_ADDR) begin
                rd_nxt[p] = rd_hi[p] ? sp_nxt[REG_W-1:DATA_W] : sp_nxt[DATA_W-1:0];
            end
            if (rd_addr[p] == FLAGS_ADDR) begin
                rd_nxt[p] = DATA_W'(flags_nxt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(N_GPR); i++) begin
                gpr_q[i] <= '0;
            end
            pc_q     <= PC_RST;
            sp_q     <= SP_RST;
            flags_q  <= '0;
            rd_data1 <= '0;
            rd_data2 <= '0;
        end else begin
            gpr_q   <= gpr_nxt;
            pc_q    <= pc_nxt;
            sp_q    <= sp_nxt;
            flags_q <= flags_nxt;
            if (rd_en) begin
                rd_data1 <= rd_nxt[0];
                rd_data2 <= rd_nxt[1];
            end
        end
    end

    assign sp_out    = sp_q;
    assign flags_out = flags_q;

endmodule

// File: tb/tb_reg_file_bypass.sv
// Directed bench for reg_file_bypass: array-based reference model compared every cycle,
// plus literal expectations for the documented scenarios.
module tb_reg_file_bypass;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned N_GPR  = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned FLAG_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr1, rd_addr2;
    logic              rd_hi1, rd_hi2;
    logic [DATA_W-1:0] rd_data1, rd_data2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_hi;
    logic [DATA_W-1:0] wr_data;
    logic [1:0]        sp_op;
    logic              flag_we;
    logic [FLAG_W-1:0] flag_in;
    logic [31:0]       sp_out;
    logic [FLAG_W-1:0] flags_out;

    int vectors = 0;
    int miscompares = 0;
    bit chk = 1'b0;

    // Reference model state: index 0..7 GPR, 8 PC, 9 SP, 10 FLAGS
    logic [15:0] m_gpr [8];
    logic [31:0] m_pc, m_sp;
    logic [3:0]  m_flags;
    logic [15:0] exp_rd1, exp_rd2;

    reg_file_bypass dut (
        .clk(clk), .rst(rst), .rd_en(rd_en),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_hi1(rd_hi1), .rd_hi2(rd_hi2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_hi(wr_hi), .wr_data(wr_data),
        .sp_op(sp_op), .flag_we(flag_we), .flag_in(flag_in),
        .sp_out(sp_out), .flags_out(flags_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] m_read(input int a, input logic hi);
        if (a < 8)   return m_gpr[a];
        if (a == 8)  return hi ? m_pc[31:16] : m_pc[15:0];
        if (a == 9)  return hi ? m_sp[31:16] : m_sp[15:0];
        if (a == 10) return {12'h000, m_flags};
        return 16'h0000;
    endfunction

    // Model advances on the same edge from the same inputs
    always @(posedge clk) begin
        if (rst !== 1'b1) begin
            for (int i = 0; i < 8; i++) m_gpr[i] = 16'h0;
            m_pc = 32'h0; m_sp = 32'd4095; m_flags = 4'h0;
            exp_rd1 = 16'h0; exp_rd2 = 16'h0;
        end else begin
            int wa;
            wa = int'(wr_addr);
            if (!(wr_en && wa == 9)) begin
                if (sp_op == 2'b01)      m_sp = m_sp - 32'd1;
                else if (sp_op == 2'b10) m_sp = m_sp + 32'd1;
            end
            if (flag_we && !(wr_en && wa == 10)) m_flags = flag_in;
            if (wr_en) begin
                if (wa < 8) m_gpr[wa] = wr_data;
                else if (wa == 8) begin
                    if (wr_hi) m_pc[31:16] = wr_data; else m_pc[15:0] = wr_data;
                end else if (wa == 9) begin
                    if (wr_hi) m_sp[31:16] = wr_data; else m_sp[15:0] = wr_data;
                end else if (wa == 10) m_flags = wr_data[3:0];
            end
            if (rd_en) begin
                exp_rd1 = m_read(int'(rd_addr1), rd_hi1);
                exp_rd2 = m_read(int'(rd_addr2), rd_hi2);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle model comparison on the falling edge
    always @(negedge clk) begin
        if (chk) begin
            check("rd_data1", 32'(rd_data1), 32'(exp_rd1));
            check("rd_data2", 32'(rd_data2), 32'(exp_rd2));
            check("sp_out",   sp_out, m_sp);
            check("flags_out", 32'(flags_out), 32'(m_flags));
        end
    end

    task automatic defaults();
        rst = 1'b1; rd_en = 1'b0; rd_addr1 = '0; rd_addr2 = '0; rd_hi1 = 1'b0; rd_hi2 = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_hi = 1'b0; wr_data = '0;
        sp_op = 2'b00; flag_we = 1'b0; flag_in = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        defaults();
    endtask

    task automatic wr(input int a, input logic hi, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_hi = hi; wr_data = d;
    endtask

    task automatic rd(input int a1, input logic h1, input int a2, input logic h2);
        rd_en = 1'b1; rd_addr1 = ADDR_W'(a1); rd_hi1 = h1; rd_addr2 = ADDR_W'(a2); rd_hi2 = h2;
    endtask

    initial begin
        defaults();
        rst = 1'b0; tick();
        rst = 1'b0; tick();
        chk = 1'b1;
        check("rst_rd1", 32'(rd_data1), 32'h0);
        check("rst_sp", sp_out, 32'h0000_0FFF);
        check("rst_flags", 32'(flags_out), 32'h0);

        rd(9, 1'b0, 9, 1'b1); tick();
        check("sp_lo_rd", 32'(rd_data1), 32'h0FFF);
        check("sp_hi_rd", 32'(rd_data2), 32'h0000);

        wr(3, 1'b0, 16'hBEEF); rd(3, 1'b0, 0, 1'b0); tick();
        check("bypass_r3", 32'(rd_data1), 32'hBEEF);
        rd_addr1 = 4'd5; tick();
        check("hold_rd1", 32'(rd_data1), 32'hBEEF);

        wr(9, 1'b1, 16'h1234); tick();
        wr(9, 1'b0, 16'h0000); tick();
        sp_op = 2'b01; tick();
        check("push", sp_out, 32'h1233_FFFF);
        sp_op = 2'b10; tick();
        sp_op = 2'b10; tick();
        check("pop2", sp_out, 32'h1234_0001);
        wr(9, 1'b0, 16'h0000); tick();
        wr(9, 1'b1, 16'h0000); tick();
        sp_op = 2'b01; rd(9, 1'b1, 9, 1'b0); tick();
        check("push_wrap", sp_out, 32'hFFFF_FFFF);
        check("push_wrap_rd", 32'(rd_data1), 32'hFFFF);
        sp_op = 2'b10; tick();
        check("pop_wrap", sp_out, 32'h0);

        wr(9, 1'b0, 16'h00AA); sp_op = 2'b01; rd(9, 1'b0, 9, 1'b1); tick();
        check("wr_beats_push", sp_out, 32'h0000_00AA);
        check("wr_beats_push_rd", 32'(rd_data1), 32'h00AA);
        wr(10, 1'b0, 16'h0005); flag_we = 1'b1; flag_in = 4'hA; tick();
        check("wr_beats_flag", 32'(flags_out), 32'h5);
        flag_we = 1'b1; flag_in = 4'hA; rd(10, 1'b0, 10, 1'b1); tick();
        check("flag_bypass", 32'(rd_data1), 32'h000A);

        for (int i = 0; i < 8; i++) begin
            wr(i, 1'b0, 16'(16'h1111 * (i + 1))); rd(i, 1'b0, (i + 7) % 8, 1'b0); tick();
        end
        wr(8, 1'b1, 16'hCAFE); rd(8, 1'b1, 8, 1'b0); tick();
        wr(8, 1'b0, 16'h0042); rd(8, 1'b1, 8, 1'b0); tick();
        check("pc_hi", 32'(rd_data1), 32'hCAFE);
        check("pc_lo", 32'(rd_data2), 32'h0042);

        wr(14, 1'b0, 16'hFFFF); rd(14, 1'b0, 11, 1'b0); tick();
        check("unmapped_rd", 32'(rd_data1), 32'h0);
        rd(0, 1'b0, 7, 1'b0); tick();
        check("r0_intact", 32'(rd_data1), 32'h1111);
        check("r7_intact", 32'(rd_data2), 32'h8888);

        rst = 1'b0; wr(1, 1'b0, 16'h5555); sp_op = 2'b01; rd(1, 1'b0, 9, 1'b0); tick();
        check("rst_wr_rd1", 32'(rd_data1), 32'h0);
        check("rst_wr_rd2", 32'(rd_data2), 32'h0);
        check("rst_wr_sp", sp_out, 32'h0000_0FFF);
        rd(1, 1'b0, 8, 1'b0); tick();
        check("rst_r1", 32'(rd_data1), 32'h0);
        tick();

        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
